// File: rtl/rv_wb_pkg.sv
// Shared types for the write-back controller: load funct3 encoding,
// load-queue entry layout and the load extract/extend helper.
package rv_wb_pkg;

  localparam int XLEN_DEF = 64;

  typedef enum logic [2:0] {
    LB  = 3'd0,
    LH  = 3'd1,
    LW  = 3'd2,
    LD  = 3'd3,
    LBU = 3'd4,
    LHU = 3'd5,
    LWU = 3'd6
  } ld_f3_e;

  typedef struct packed {
    logic [4:0] rd;
    ld_f3_e     funct3;
    logic [2:0] off;
  } lq_entry_t;

  // Offset bits below the access size are ignored (natural alignment).
  function automatic logic [XLEN_DEF-1:0] ld_extract(
    input logic [XLEN_DEF-1:0] d,
    input ld_f3_e              f3,
    input logic [2:0]          off
  );
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] w;
    logic [XLEN_DEF-1:0] r;
    b = d[{off, 3'b000} +: 8];
    h = d[{off[2:1], 4'b0000} +: 16];
    w = d[{off[2], 5'b00000} +: 32];
    case (f3)
      LB:      r = {{56{b[7]}}, b};
      LH:      r = {{48{h[15]}}, h};
      LW:      r = {{32{w[31]}}, w};
      LBU:     r = {56'd0, b};
      LHU:     r = {48'd0, h};
      LWU:     r = {32'd0, w};
      default: r = d;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/rv_wb_ctrl_if.sv
// Write-back bus: ALU result, load issue, load response, busy and
// register-file write port. master = producers/consumers, slave = controller.
interface rv_wb_ctrl_if #(
  parameter int XLEN = 64
);

  logic            alu_valid;
  logic            alu_ready;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_data;

  logic            ld_req_valid;
  logic            ld_req_ready;
  logic [4:0]      ld_req_rd;
  logic [2:0]      ld_req_funct3;
  logic [2:0]      ld_req_off;

  logic            ld_rsp_valid;
  logic [XLEN-1:0] ld_rsp_data;

  logic [31:0]     busy;
  logic            wr_en;
  logic [4:0]      wr_idx;
  logic [XLEN-1:0] wr_data;

  modport master (
    output alu_valid, alu_rd, alu_data,
    output ld_req_valid, ld_req_rd,
    output ld_req_funct3, ld_req_off,
    output ld_rsp_valid, ld_rsp_data,
    input  alu_ready, ld_req_ready,
    input  busy, wr_en, wr_idx, wr_data
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  ld_req_valid, ld_req_rd,
    input  ld_req_funct3, ld_req_off,
    input  ld_rsp_valid, ld_rsp_data,
    output alu_ready, ld_req_ready,
    output busy, wr_en, wr_idx, wr_data
  );

endinterface

// File: rtl/rv_wb_lq.sv
// Outstanding-load FIFO of lq_entry_t, in-order. Ports: clk, rst (sync),
// push/din, pop/dout (head), full, empty. Pointers carry a wrap bit.
module rv_wb_lq
  import rv_wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  lq_entry_t din,
  input  logic      pop,
  output lq_entry_t dout,
  output logic      full,
  output logic      empty
);

  localparam int AW = $clog2(DEPTH);

  lq_entry_t   mem [DEPTH];
  logic [AW:0] wp;
  logic [AW:0] rp;

  assign empty = (wp == rp);
  assign full  = (wp[AW] != rp[AW]) &&
                 (wp[AW-1:0] == rp[AW-1:0]);
  assign dout  = mem[rp[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push && !full)
      mem[wp[AW-1:0]] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push && !full)
        wp <= wp + 1'b1;
      if (pop && !empty)
        rp <= rp + 1'b1;
    end
  end

endmodule

// File: rtl/rv_wb_ctrl.sv
// Write-back controller: sole register-file writer, merges ALU results with
// in-order load responses, aligns/extends load data, tracks busy registers.
// Ports: clk, rst (sync, active-high), bus (rv_wb_ctrl_if.slave).
// Macro RV_WB_FWD_EN adds rs1/rs2 bypass ports (rs*_idx, rf_rs*, rs*_fwd).
module rv_wb_ctrl
  import rv_wb_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int LQ_DEPTH = 4
) (
  input logic          clk,
  input logic          rst,
  rv_wb_ctrl_if.slave  bus
`ifdef RV_WB_FWD_EN
  ,
  input  logic [4:0]      rs1_idx,
  input  logic [4:0]      rs2_idx,
  input  logic [XLEN-1:0] rf_rs1,
  input  logic [XLEN-1:0] rf_rs2,
  output logic [XLEN-1:0] rs1_fwd,
  output logic [XLEN-1:0] rs2_fwd
`endif
);

  lq_entry_t       lq_din;
  lq_entry_t       lq_head;
  logic            lq_full;
  logic            lq_empty;
  logic            push;
  logic            pop;
  logic            alu_rdy;
  logic            ld_rdy;
  logic            alu_go;
  logic [31:0]     set_mask;
  logic [31:0]     clr_mask;

  logic [31:0]     busy_q;
  logic            wr_en_q;
  logic [4:0]      wr_idx_q;
  logic [XLEN-1:0] wr_data_q;

  assign lq_din = '{
    rd:     bus.ld_req_rd,
    funct3: ld_f3_e'(bus.ld_req_funct3),
    off:    bus.ld_req_off
  };

  // rd 0 never becomes busy, so the index-0 lookup is harmless.
  assign ld_rdy  = ~rst & ~lq_full &
                   ~busy_q[bus.ld_req_rd];
  assign alu_rdy = ~rst & ~bus.ld_rsp_valid;

  assign push   = bus.ld_req_valid & ld_rdy;
  assign pop    = bus.ld_rsp_valid & ~lq_empty & ~rst;
  assign alu_go = bus.alu_valid & alu_rdy;

  assign set_mask = push ?
    ((32'd1 << bus.ld_req_rd) & ~32'd1) : 32'd0;
  assign clr_mask = pop ?
    (32'd1 << lq_head.rd) : 32'd0;

  rv_wb_lq #(
    .DEPTH (LQ_DEPTH)
  ) u_lq (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (lq_din),
    .pop   (pop),
    .dout  (lq_head),
    .full  (lq_full),
    .empty (lq_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_idx_q  <= '0;
      wr_data_q <= '0;
    end else begin
      busy_q <= (busy_q & ~clr_mask) | set_mask;
      if (pop) begin
        wr_en_q   <= (lq_head.rd != 5'd0);
        wr_idx_q  <= lq_head.rd;
        wr_data_q <= ld_extract(bus.ld_rsp_data,
                                lq_head.funct3,
                                lq_head.off);
      end else if (alu_go) begin
        wr_en_q   <= (bus.alu_rd != 5'd0);
        wr_idx_q  <= bus.alu_rd;
        wr_data_q <= bus.alu_data;
      end else begin
        wr_en_q <= 1'b0;
      end
    end
  end

  assign bus.alu_ready    = alu_rdy;
  assign bus.ld_req_ready = ld_rdy;
  assign bus.busy         = busy_q;
  assign bus.wr_en        = wr_en_q;
  assign bus.wr_idx       = wr_idx_q;
  assign bus.wr_data      = wr_data_q;

`ifdef RV_WB_FWD_EN
  assign rs1_fwd = (wr_en_q && wr_idx_q == rs1_idx &&
                    rs1_idx != 5'd0) ? wr_data_q : rf_rs1;
  assign rs2_fwd = (wr_en_q && wr_idx_q == rs2_idx &&
                    rs2_idx != 5'd0) ? wr_data_q : rf_rs2;
`endif

  a_rsp_empty: assert property (
    @(posedge clk) disable iff (rst)
    !(bus.ld_rsp_valid && lq_empty));

  a_alu_busy: assert property (
    @(posedge clk) disable iff (rst)
    !(alu_go && busy_q[bus.alu_rd]));

endmodule

// File: tb/tb_rv_wb_ctrl.sv
// Testbench for rv_wb_ctrl: directed cases plus random traffic checked
// against a queue-based reference model of the write-back rules.
module tb_rv_wb_ctrl;

  localparam int F_LB  = 0;
  localparam int F_LH  = 1;
  localparam int F_LW  = 2;
  localparam int F_LD  = 3;
  localparam int F_LBU = 4;
  localparam int F_LHU = 5;
  localparam int F_LWU = 6;
  localparam int LQ    = 4;

  logic clk;
  logic rst;

  rv_wb_ctrl_if #(.XLEN(64)) bif ();

`ifdef RV_WB_FWD_EN
  logic [63:0] rs1_fwd;
  logic [63:0] rs2_fwd;
  rv_wb_ctrl #(.XLEN(64), .LQ_DEPTH(LQ)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bif),
    .rs1_idx (5'd0),
    .rs2_idx (5'd0),
    .rf_rs1  (64'd0),
    .rf_rs2  (64'd0),
    .rs1_fwd (rs1_fwd),
    .rs2_fwd (rs2_fwd)
  );
`else
  rv_wb_ctrl #(.XLEN(64), .LQ_DEPTH(LQ)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  int          q_rd  [$];
  int          q_f3  [$];
  int          q_off [$];
  logic [31:0] mbusy;
  bit          exp_wen;
  logic [4:0]  exp_idx;
  logic [63:0] exp_data;
  bit          alu_acc;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h t=%0t",
                  tag, got, exp, $time);
  endtask

  // Naturally aligned field of size 2^(f3%4) bytes, then extended.
  function automatic logic [63:0] ref_ld(input logic [63:0] d,
                                         input int f3,
                                         input int off);
    int sz;
    int a;
    logic [63:0] m;
    logic [63:0] v;
    sz = 1 << (f3 % 4);
    a  = off - (off % sz);
    m  = (sz == 8) ? '1 : ((64'd1 << (8 * sz)) - 64'd1);
    v  = (d >> (8 * a)) & m;
    if (f3 < 3 && v[8 * sz - 1]) v = v | ~m;
    return v;
  endfunction

  task automatic set_in(input bit av, input logic [4:0] ar,
                        input logic [63:0] ad, input bit lv,
                        input logic [4:0] lr, input int lf,
                        input int lo, input bit rv,
                        input logic [63:0] rdat);
    bif.alu_valid     = av;
    bif.alu_rd        = ar;
    bif.alu_data      = ad;
    bif.ld_req_valid  = lv;
    bif.ld_req_rd     = lr;
    bif.ld_req_funct3 = 3'(lf);
    bif.ld_req_off    = 3'(lo);
    bif.ld_rsp_valid  = rv;
    bif.ld_rsp_data   = rdat;
  endtask

  task automatic step(input bit av, input logic [4:0] ar,
                      input logic [63:0] ad, input bit lv,
                      input logic [4:0] lr, input int lf,
                      input int lo, input bit rv,
                      input logic [63:0] rdat);
    bit er_alu;
    bit er_ld;
    int r;
    int f;
    int o;
    set_in(av, ar, ad, lv, lr, lf, lo, rv, rdat);
    #1;
    er_alu = !rv;
    er_ld  = (q_rd.size() < LQ) &&
             (lr == 0 || !mbusy[lr]);
    chk("alu_ready", 64'(bif.alu_ready), 64'(er_alu));
    chk("ld_req_ready", 64'(bif.ld_req_ready), 64'(er_ld));
    exp_wen = 0;
    if (rv && q_rd.size() > 0) begin
      r = q_rd.pop_front();
      f = q_f3.pop_front();
      o = q_off.pop_front();
      exp_wen  = (r != 0);
      exp_idx  = 5'(r);
      exp_data = ref_ld(rdat, f, o);
      mbusy[r] = 1'b0;
    end else if (av && er_alu) begin
      exp_wen  = (ar != 0);
      exp_idx  = ar;
      exp_data = ad;
    end
    alu_acc = av && er_alu;
    if (lv && er_ld) begin
      q_rd.push_back(int'(lr));
      q_f3.push_back(lf);
      q_off.push_back(lo);
      if (lr != 0) mbusy[lr] = 1'b1;
    end
    @(posedge clk);
    #1;
    chk("wr_en", 64'(bif.wr_en), 64'(exp_wen));
    if (exp_wen) begin
      chk("wr_idx", 64'(bif.wr_idx), 64'(exp_idx));
      chk("wr_data", bif.wr_data, exp_data);
    end
    chk("busy", 64'(bif.busy), 64'(mbusy));
  endtask

  task automatic alu_op(input logic [4:0] rd, input logic [63:0] d);
    step(1, rd, d, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic ld_iss(input logic [4:0] rd, input int f3, input int off);
    step(0, 0, 0, 1, rd, f3, off, 0, 0);
  endtask

  task automatic ld_rsp(input logic [63:0] d);
    step(0, 0, 0, 0, 0, 0, 0, 1, d);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_in(0, 0, 0, 1, 5'd3, 0, 0, 0, 0);
    bif.alu_valid = 1'b1;
    #1;
    chk("rst_alu_ready", 64'(bif.alu_ready), 64'd0);
    chk("rst_ld_ready", 64'(bif.ld_req_ready), 64'd0);
    @(posedge clk);
    #1;
    chk("rst_wr_en", 64'(bif.wr_en), 64'd0);
    chk("rst_wr_idx", 64'(bif.wr_idx), 64'd0);
    chk("rst_wr_data", bif.wr_data, 64'd0);
    chk("rst_busy", 64'(bif.busy), 64'd0);
    rst = 1'b0;
    q_rd.delete();
    q_f3.delete();
    q_off.delete();
    mbusy   = '0;
    exp_wen = 0;
  endtask

  initial begin
    bit          av;
    logic [4:0]  ar;
    logic [63:0] ad;
    bit          lv;
    logic [4:0]  lr;
    int          lf;
    int          lo;
    bit          rv;

    rst = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    mbusy = '0;
    do_reset();

    alu_op(5, 64'h1234);
    chk("alu_val", bif.wr_data, 64'h1234);
    alu_op(0, 64'hdead);
    chk("alu_rd0", 64'(bif.wr_en), 64'd0);

    ld_iss(7, F_LB, 3);
    ld_rsp(64'h0000_0000_8000_0000);
    chk("lb_val", bif.wr_data, 64'hFFFF_FFFF_FFFF_FF80);
    ld_iss(7, F_LBU, 3);
    ld_rsp(64'h0000_0000_8000_0000);
    chk("lbu_val", bif.wr_data, 64'h80);
    ld_iss(7, F_LW, 4);
    ld_rsp(64'h8765_4321_0000_0000);
    chk("lw_val", bif.wr_data, 64'hFFFF_FFFF_8765_4321);
    ld_iss(7, F_LWU, 5);
    ld_rsp(64'h8765_4321_0000_0000);
    chk("lwu_val", bif.wr_data, 64'h0000_0000_8765_4321);
    ld_iss(7, F_LD, 6);
    ld_rsp(64'h8765_4321_0BAD_F00D);
    chk("ld_val", bif.wr_data, 64'h8765_4321_0BAD_F00D);
    ld_iss(0, F_LH, 2);
    ld_rsp(64'h1111_2222_3333_4444);
    chk("ld_rd0", 64'(bif.wr_en), 64'd0);

    ld_iss(8, F_LHU, 2);
    step(1, 20, 64'h55, 0, 0, 0, 0, 1, 64'h0000_0000_ABCD_0000);
    chk("conf_ld_idx", 64'(bif.wr_idx), 64'd8);
    alu_op(20, 64'h55);
    chk("conf_alu_idx", 64'(bif.wr_idx), 64'd20);

    for (int i = 1; i <= 4; i++) ld_iss(5'(i), F_LW, 0);
    chk("full_busy", 64'(bif.busy), 64'h1E);
    ld_iss(1, F_LW, 0);
    ld_rsp(64'h1);
    chk("busy_pop1", 64'(bif.busy), 64'h1C);
    for (int i = 0; i < 3; i++) ld_rsp(64'(i + 2));

    ld_iss(9, F_LW, 0);
    ld_iss(10, F_LD, 0);
    do_reset();
    ld_iss(9, F_LH, 6);
    ld_rsp(64'h8001_0000_0000_0000);
    chk("post_rst_ld", bif.wr_data, 64'hFFFF_FFFF_FFFF_8001);

    alu_acc = 1'b1;
    av = 0; ar = 0; ad = 0;
    for (int c = 0; c < 800; c++) begin
      if (alu_acc || !av) begin
        av = ($urandom % 2) == 1;
        ar = ($urandom % 5 == 0) ? 5'd0 : 5'(16 + $urandom % 16);
        ad = {$urandom, $urandom};
      end
      lv = ($urandom % 3) != 0;
      lr = 5'($urandom % 16);
      lf = int'($urandom % 7);
      lo = int'($urandom % 8);
      rv = (q_rd.size() > 0) && ($urandom % 2 == 1);
      step(av, ar, ad, lv, lr, lf, lo, rv, {$urandom, $urandom});
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
